// File: rtl/control_traseu.sv
// Line-follower controller: synchronised sensor bar in, wheel direction/duty words out.
// Tracks lap markers, searches for a lost line and parks on completed circuits.
module control_traseu #(
  parameter int                   NR_SENZORI  = 5,
  parameter int                   LATIME_DC   = 12,
  parameter logic [LATIME_DC-1:0] DC_MAX      = 'h999,
  parameter logic [LATIME_DC-1:0] DC_MIN      = 'h650,
  parameter logic [LATIME_DC-1:0] DC_CAUTARE  = 'h800,
  parameter int                   T_DEBOUNCE  = 16,
  parameter int                   T_CAUTARE   = 50000,
  parameter int                   LATIME_TURE = 8,
  parameter int                   TURE_CURBE  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NR_SENZORI-1:0]  senzori,
  input  logic [1:0]             circuit,
  output logic [1:0]             directie_driverA,
  output logic [1:0]             directie_driverB,
  output logic [LATIME_DC-1:0]   factor_dc_driverA,
  output logic [LATIME_DC-1:0]   factor_dc_driverB,
  output logic                   semnal_dreapta,
  output logic                   semnal_stanga,
  output logic                   stop,
  output logic [LATIME_TURE-1:0] count_ture,
  output logic [2:0]             stare,
  output logic                   linie_pierduta
);

  localparam int C      = (NR_SENZORI - 1) / 2;
  localparam int DEB_W  = $clog2(T_DEBOUNCE + 1);
  localparam int SRCH_W = $clog2(T_CAUTARE + 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] URMARIRE   = 3'd1;
  localparam logic [2:0] CAUTARE_DR = 3'd2;
  localparam logic [2:0] CAUTARE_ST = 3'd3;
  localparam logic [2:0] OPRIT      = 3'd4;
  localparam logic [2:0] PIERDUT    = 3'd5;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_DR   = 2'b01;
  localparam logic [1:0] MEM_ST   = 2'b10;

  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_BRK = 2'b00;

  localparam logic [DEB_W-1:0]       DEB_LAST  = DEB_W'(T_DEBOUNCE - 1);
  localparam logic [SRCH_W-1:0]      SRCH_LAST = SRCH_W'(T_CAUTARE - 1);
  localparam logic [LATIME_TURE-1:0] TURE_ONE  = LATIME_TURE'(1);
  localparam logic [LATIME_TURE-1:0] TURE_CRB  = LATIME_TURE'(TURE_CURBE);

  // Two-flop synchronisers
  logic [NR_SENZORI-1:0] senz_m, senz_s;
  logic [1:0]            circ_m, circ_s;

  logic [2:0]             state_q, state_d;
  logic [1:0]             mem_q, mem_d;
  logic [SRCH_W-1:0]      srch_q, srch_d;
  logic [DEB_W-1:0]       deb_q, deb_d;
  logic                   blocat_q, blocat_d;
  logic [LATIME_TURE-1:0] count_d;
  logic                   lost_d;

  logic                   right_any, left_any, center, fin;
  logic                   lap_inc, lap_done, lap_stop;
  logic [1:0]             dir_a_d, dir_b_d;
  logic [LATIME_DC-1:0]   dc_a_d, dc_b_d;
  logic                   stop_d;

  always_comb begin
    right_any = 1'b0;
    left_any  = 1'b0;
    for (int i = 1; i < C; i++) right_any = right_any | senz_s[i];
    for (int i = C + 1; i < NR_SENZORI - 1; i++) left_any = left_any | senz_s[i];
  end

  assign center = senz_s[C];
  assign fin    = senz_s[0] & senz_s[NR_SENZORI-1];

  // Debounce: while unlocked count stable finish cycles, while locked count stable clear cycles.
  always_comb begin
    deb_d    = deb_q;
    blocat_d = blocat_q;
    lap_inc  = 1'b0;
    if (circ_s == 2'b00) begin
      deb_d    = '0;
      blocat_d = 1'b0;
    end else if (fin == blocat_q) begin
      deb_d = '0;
    end else if (deb_q == DEB_LAST) begin
      deb_d    = '0;
      blocat_d = ~blocat_q;
      lap_inc  = ~blocat_q;
    end else begin
      deb_d = deb_q + 1'b1;
    end
  end

  always_comb begin
    lap_done = lap_inc && (count_ture != '1);
    if (circ_s == 2'b00) begin
      count_d = '0;
    end else if (lap_done) begin
      count_d = count_ture + 1'b1;
    end else begin
      count_d = count_ture;
    end
    lap_stop = lap_done && (((circ_s == 2'b01) && (count_d == TURE_ONE)) ||
                            ((circ_s == 2'b10) && (count_d == TURE_CRB)));
  end

  always_comb begin
    mem_d = mem_q;
    if (circ_s == 2'b00) begin
      mem_d = MEM_NONE;
    end else if (center && right_any && !left_any) begin
      mem_d = MEM_DR;
    end else if (center && left_any && !right_any) begin
      mem_d = MEM_ST;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (circ_s != 2'b00) state_d = URMARIRE;
      end
      URMARIRE: begin
        // Finish markers alone never mean the line was lost.
        if (!center && !right_any && !left_any && !fin) begin
          if (mem_q == MEM_DR) begin
            state_d = CAUTARE_DR;
          end else if (mem_q == MEM_ST) begin
            state_d = CAUTARE_ST;
          end
        end
      end
      CAUTARE_DR, CAUTARE_ST: begin
        if (center) begin
          state_d = URMARIRE;
        end else if (srch_q == SRCH_LAST) begin
          state_d = PIERDUT;
        end
      end
      default: state_d = state_q;
    endcase
    if (lap_stop && (state_d == URMARIRE || state_d == CAUTARE_DR || state_d == CAUTARE_ST)) begin
      state_d = OPRIT;
    end
    if (circ_s == 2'b00) state_d = IDLE;
  end

  always_comb begin
    if ((state_d == state_q) && (state_q == CAUTARE_DR || state_q == CAUTARE_ST)) begin
      srch_d = srch_q + 1'b1;
    end else begin
      srch_d = '0;
    end
  end

  always_comb begin
    if (circ_s == 2'b00) begin
      lost_d = 1'b0;
    end else if (state_d == PIERDUT) begin
      lost_d = 1'b1;
    end else begin
      lost_d = linie_pierduta;
    end
  end

  // Drive words follow the state being entered so they line up with stare.
  always_comb begin
    dir_a_d = DIR_BRK;
    dir_b_d = DIR_BRK;
    dc_a_d  = '0;
    dc_b_d  = '0;
    stop_d  = 1'b1;
    case (state_d)
      URMARIRE: begin
        stop_d  = ~center;
        dir_a_d = DIR_FWD;
        dir_b_d = DIR_FWD;
        dc_a_d  = DC_MAX;
        dc_b_d  = DC_MAX;
        if (right_any && !left_any) begin
          dir_a_d = DIR_REV;
          dc_a_d  = center ? DC_MIN : DC_CAUTARE;
        end else if (left_any && !right_any) begin
          dir_b_d = DIR_REV;
          dc_b_d  = center ? DC_MIN : DC_CAUTARE;
        end
      end
      CAUTARE_DR: begin
        dir_a_d = DIR_REV;
        dir_b_d = DIR_FWD;
        dc_a_d  = DC_CAUTARE;
        dc_b_d  = DC_MAX;
      end
      CAUTARE_ST: begin
        dir_a_d = DIR_FWD;
        dir_b_d = DIR_REV;
        dc_a_d  = DC_MAX;
        dc_b_d  = DC_CAUTARE;
      end
      default: begin
        dir_a_d = DIR_BRK;
        dir_b_d = DIR_BRK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      senz_m            <= '0;
      senz_s            <= '0;
      circ_m            <= '0;
      circ_s            <= '0;
      state_q           <= IDLE;
      mem_q             <= MEM_NONE;
      srch_q            <= '0;
      deb_q             <= '0;
      blocat_q          <= 1'b0;
      count_ture        <= '0;
      linie_pierduta    <= 1'b0;
      directie_driverA  <= DIR_BRK;
      directie_driverB  <= DIR_BRK;
      factor_dc_driverA <= '0;
      factor_dc_driverB <= '0;
      semnal_dreapta    <= 1'b0;
      semnal_stanga     <= 1'b0;
      stop              <= 1'b1;
    end else begin
      senz_m            <= senzori;
      senz_s            <= senz_m;
      circ_m            <= circuit;
      circ_s            <= circ_m;
      state_q           <= state_d;
      mem_q             <= mem_d;
      srch_q            <= srch_d;
      deb_q             <= deb_d;
      blocat_q          <= blocat_d;
      count_ture        <= count_d;
      linie_pierduta    <= lost_d;
      directie_driverA  <= dir_a_d;
      directie_driverB  <= dir_b_d;
      factor_dc_driverA <= dc_a_d;
      factor_dc_driverB <= dc_b_d;
      semnal_dreapta    <= senz_s[0];
      semnal_stanga     <= senz_s[NR_SENZORI-1];
      stop              <= stop_d;
    end
  end

  assign stare = state_q;

endmodule

// File: tb/tb_control_traseu.sv
// Scoreboard bench for control_traseu: expected outputs queued with each stimulus,
// compared once the three-edge input latency has elapsed.
module tb_control_traseu;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  senzori;
  logic [1:0]  circuit;
  logic [1:0]  directie_driverA, directie_driverB;
  logic [11:0] factor_dc_driverA, factor_dc_driverB;
  logic        semnal_dreapta, semnal_stanga, stop;
  logic [7:0]  count_ture;
  logic [2:0]  stare;
  logic        linie_pierduta;

  control_traseu #(
    .NR_SENZORI (5),
    .T_DEBOUNCE (4),
    .T_CAUTARE  (20)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .senzori           (senzori),
    .circuit           (circuit),
    .directie_driverA  (directie_driverA),
    .directie_driverB  (directie_driverB),
    .factor_dc_driverA (factor_dc_driverA),
    .factor_dc_driverB (factor_dc_driverB),
    .semnal_dreapta    (semnal_dreapta),
    .semnal_stanga     (semnal_stanga),
    .stop              (stop),
    .count_ture        (count_ture),
    .stare             (stare),
    .linie_pierduta    (linie_pierduta)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [1:0]  da;
    logic [1:0]  db;
    logic [11:0] ca;
    logic [11:0] cb;
    logic        stp;
    logic [7:0]  cnt;
    logic        lost;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [2:0] st, input logic [1:0] da,
                         input logic [1:0] db, input logic [11:0] ca, input logic [11:0] cb,
                         input logic stp, input logic [7:0] cnt, input logic lost);
    exp_t e;
    e.tag  = tag;
    e.st   = st;
    e.da   = da;
    e.db   = db;
    e.ca   = ca;
    e.cb   = cb;
    e.stp  = stp;
    e.cnt  = cnt;
    e.lost = lost;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_val({e.tag, ".stare"}, 32'(stare), 32'(e.st));
    check_val({e.tag, ".dirA"}, 32'(directie_driverA), 32'(e.da));
    check_val({e.tag, ".dirB"}, 32'(directie_driverB), 32'(e.db));
    check_val({e.tag, ".dcA"}, 32'(factor_dc_driverA), 32'(e.ca));
    check_val({e.tag, ".dcB"}, 32'(factor_dc_driverB), 32'(e.cb));
    check_val({e.tag, ".stop"}, 32'(stop), 32'(e.stp));
    check_val({e.tag, ".ture"}, 32'(count_ture), 32'(e.cnt));
    check_val({e.tag, ".lost"}, 32'(linie_pierduta), 32'(e.lost));
  endtask

  // Drive inputs, queue the expectation, compare after the 3-edge latency.
  task automatic step(input string tag, input logic [4:0] s, input logic [1:0] c,
                      input logic [2:0] st, input logic [1:0] da, input logic [1:0] db,
                      input logic [11:0] ca, input logic [11:0] cb, input logic stp,
                      input logic [7:0] cnt, input logic lost);
    senzori = s;
    circuit = c;
    sb_push(tag, st, da, db, ca, cb, stp, cnt, lost);
    repeat (3) @(negedge clk);
    sb_check();
  endtask

  task automatic lap(input int hold, input int gap);
    senzori = 5'b10001;
    repeat (hold) @(negedge clk);
    senzori = 5'b00000;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst     = 1'b1;
    senzori = '0;
    circuit = 2'b00;
    @(negedge clk);
    sb_push("rst", 3'd0, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 8'd0, 1'b0);
    sb_check();
    check_val("rst.lampR", 32'(semnal_dreapta), 32'd0);
    rst = 1'b0;

    step("fwd",     5'b00100, 2'b11, 3'd1, 2'b10, 2'b10, 12'h999, 12'h999, 1'b0, 8'd0, 1'b0);
    step("dr_nc",   5'b00010, 2'b11, 3'd1, 2'b01, 2'b10, 12'h800, 12'h999, 1'b1, 8'd0, 1'b0);
    step("both",    5'b01110, 2'b11, 3'd1, 2'b10, 2'b10, 12'h999, 12'h999, 1'b0, 8'd0, 1'b0);
    step("dr",      5'b00110, 2'b11, 3'd1, 2'b01, 2'b10, 12'h650, 12'h999, 1'b0, 8'd0, 1'b0);
    step("srch_dr", 5'b00000, 2'b11, 3'd2, 2'b01, 2'b10, 12'h800, 12'h999, 1'b1, 8'd0, 1'b0);
    step("back",    5'b00100, 2'b11, 3'd1, 2'b10, 2'b10, 12'h999, 12'h999, 1'b0, 8'd0, 1'b0);
    step("st",      5'b01100, 2'b11, 3'd1, 2'b10, 2'b01, 12'h999, 12'h650, 1'b0, 8'd0, 1'b0);
    step("srch_st", 5'b00000, 2'b11, 3'd3, 2'b10, 2'b01, 12'h999, 12'h800, 1'b1, 8'd0, 1'b0);

    // Twenty cycles in the search state, then the line is declared lost.
    k = 0;
    while (stare != 3'd5 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("lost_lat", 32'(k), 32'd20);
    step("lost",    5'b00000, 2'b11, 3'd5, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 8'd0, 1'b1);
    step("clr",     5'b00000, 2'b00, 3'd0, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 8'd0, 1'b0);

    circuit = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      lap(4, 4);
      check_val("curbe.ture", 32'(count_ture), 32'(i));
      check_val("curbe.stare", 32'(stare), (i == 10) ? 32'd4 : 32'd1);
    end
    step("oprit",   5'b00000, 2'b10, 3'd4, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 8'd10, 1'b0);
    step("clr2",    5'b00000, 2'b00, 3'd0, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 8'd0, 1'b0);

    circuit = 2'b01;
    lap(4, 4);
    check_val("drept.ture", 32'(count_ture), 32'd1);
    check_val("drept.stare", 32'(stare), 32'd4);
    step("clr3",    5'b00000, 2'b00, 3'd0, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 8'd0, 1'b0);
    step("fwd2",    5'b00100, 2'b11, 3'd1, 2'b10, 2'b10, 12'h999, 12'h999, 1'b0, 8'd0, 1'b0);

    senzori = 5'b10001;
    repeat (3) @(negedge clk);
    check_val("glitch.lampR", 32'(semnal_dreapta), 32'd1);
    check_val("glitch.lampL", 32'(semnal_stanga), 32'd1);
    check_val("glitch.stop", 32'(stop), 32'd1);
    senzori = 5'b00000;
    repeat (5) @(negedge clk);
    check_val("glitch.ture", 32'(count_ture), 32'd0);
    check_val("glitch.lampL0", 32'(semnal_stanga), 32'd0);

    lap(12, 4);
    check_val("long.ture", 32'(count_ture), 32'd1);
    for (int i = 0; i < 259; i++) lap(4, 4);
    check_val("sat.ture", 32'(count_ture), 32'd255);
    check_val("sat.stare", 32'(stare), 32'd1);

    senzori = 5'b10001;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb_push("rst_mid", 3'd0, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 8'd0, 1'b0);
    #1;
    sb_check();
    check_val("rst_mid.lampR", 32'(semnal_dreapta), 32'd0);
    check_val("rst_mid.lampL", 32'(semnal_stanga), 32'd0);

    @(negedge clk);
    senzori = 5'b00100;
    rst     = 1'b0;
    repeat (2) @(negedge clk);
    check_val("resume.idle", 32'(stare), 32'd0);
    @(negedge clk);
    check_val("resume.urm", 32'(stare), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
